// File: rtl/sinc_loop_ctr.sv
// rtl/sinc_loop_ctr.sv - registered signed loop-index stage around the SINC incrementer
module sinc_loop_ctr #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] init,
  input  logic [DATAWIDTH-1:0] bound,
  output logic [DATAWIDTH-1:0] inc_a,
  input  logic [DATAWIDTH-1:0] inc_d,
  output logic [DATAWIDTH-1:0] idx,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH:0]   count
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [DATAWIDTH:0] CNT_ONE = {{DATAWIDTH{1'b0}}, 1'b1};

  logic [1:0]           state;
  logic [DATAWIDTH-1:0] bound_q;
  logic                 accept;
  logic                 at_last;
  logic                 init_le_bound;

  // The external incrementer always works on the current index.
  assign inc_a = idx;

  // Handshake and signed comparisons that steer the loop.
  always_comb begin
    accept        = idx_valid & idx_ready;
    at_last       = ($signed(idx) == $signed(bound_q));
    init_le_bound = ($signed(init) <= $signed(bound));
  end

  // Loop sequencer: captures the range on start, advances idx from SINC on
  // each accepted index, and flags completion with a one-cycle done pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      bound_q   <= '0;
      count     <= '0;
      idx_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx     <= init;
            bound_q <= bound;
            count   <= '0;
            if (init_le_bound) begin
              state     <= ST_RUN;
              idx_valid <= 1'b1;
              busy      <= 1'b1;
            end else begin
              // Empty range: report completion without emitting anything.
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            count <= count + CNT_ONE;
            if (at_last) begin
              // Never take inc_d here, so the max-positive index cannot wrap.
              state     <= ST_DONE;
              idx_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx <= inc_d;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          idx_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
